// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: FSM encoding and
// the index-width helper used to size owner / round-robin pointers.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Width of an index into n producers; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEFAULT = 4;
    localparam int IDX_W_DEFAULT = idx_width(N_REQ_DEFAULT);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after
// rr_ptr, wrapping modulo N_REQ.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand_s;

    // Scan farthest offset first so the nearest valid index is the last write.
    always_comb begin
        found  = 1'b0;
        index  = {IDX_W{1'b0}};
        cand_s = {SUM_W{1'b0}};
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand_s = {1'b0, rr_ptr} + SUM_W'(off);
            if (cand_s >= SUM_W'(N_REQ)) begin
                cand_s = cand_s - SUM_W'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (req_valid[cand_s[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand_s[IDX_W-1:0];
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ producers,
// granting bursts of up to MAX_BURST words and stalling on fifo_full.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ack,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_data,
    input  logic                fifo_full,
    output logic [N_REQ-1:0]    grant,
    output logic                busy
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [IDX_W-1:0]  owner_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic              pick_found_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [N_REQ-1:0]  owner_onehot_s;
    logic [DW-1:0]     owner_data_s;
    logic              owner_valid_s;
    logic              accept_s;
    logic              release_s;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .found     (pick_found_s),
        .index     (pick_idx_s)
    );

    // Owner decode, accept and release conditions.
    always_comb begin
        owner_onehot_s = {N_REQ{1'b0}};
        owner_data_s   = {DW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_r == IDX_W'(i)) begin
                owner_onehot_s[i] = 1'b1;
                owner_data_s      = req_data[i*DW +: DW];
            end else begin
                owner_onehot_s[i] = 1'b0;
            end
        end
        owner_valid_s = |(req_valid & owner_onehot_s);
        accept_s      = (state_r == ST_GRANT) && owner_valid_s && !fifo_full;
        release_s     = (state_r == ST_GRANT) &&
                        ((accept_s && (beat_cnt_r == LAST_BEAT)) || !owner_valid_s);
    end

    // State register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Owner capture, round-robin pointer advance and burst counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            owner_r    <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    beat_cnt_r <= {CNT_W{1'b0}};
                    if (pick_found_s) begin
                        owner_r <= pick_idx_s;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        rr_ptr_r   <= (owner_r == LAST_IDX) ? {IDX_W{1'b0}} : owner_r + IDX_W'(1);
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end
                end
                default: beat_cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    // Outputs follow the state directly so a reset clears them at once.
    always_comb begin
        grant     = {N_REQ{1'b0}};
        req_ack   = {N_REQ{1'b0}};
        fifo_wr   = 1'b0;
        fifo_data = {DW{1'b0}};
        busy      = 1'b0;
        if (state_r == ST_GRANT) begin
            grant     = owner_onehot_s;
            req_ack   = accept_s ? owner_onehot_s : {N_REQ{1'b0}};
            fifo_wr   = accept_s;
            fifo_data = owner_data_s;
            busy      = 1'b1;
        end else begin
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random
// phase, all compared against a behavioural round-robin burst model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic          clk;
    logic          clear_n;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_ack;
    logic          fifo_wr;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic [N-1:0]  grant;
    logic          busy;

    fifo_wr_arbiter #(.N_REQ(N), .DW(8), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Producer word queues, enable mask, write log and expected log.
    logic [7:0]  pq [N][$];
    logic [N-1:0] en_mask;
    logic [11:0] wlog [$];
    logic [11:0] exp_log [$];
    int total_pushed;

    // Reference model: busy flag, owner, round-robin pointer, beats taken.
    bit   m_busy;
    int   m_owner;
    int   m_ptr;
    int   m_beats;
    logic [N-1:0] s_valid;
    bit   s_full;
    bit   s_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = en_mask[i] && (pq[i].size() > 0);
            req_data[i*8 +: 8] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
        end
    endtask

    task automatic model_step();
        bit hit;
        int idx;
        if (!m_busy) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!hit && s_valid[idx]) begin
                    hit = 1'b1; m_busy = 1'b1; m_owner = idx; m_beats = 0;
                end
            end
        end else begin
            if (s_acc) m_beats++;
            if ((s_acc && m_beats == MB) || !s_valid[m_owner]) begin
                m_busy  = 1'b0;
                m_ptr   = (m_owner + 1) % N;
                m_beats = 0;
            end
        end
    endtask

    // One clock: drive, check at negedge against the model, advance at posedge.
    task automatic cycle();
        logic [31:0] exp_oh;
        drive();
        @(negedge clk);
        s_valid = req_valid;
        s_full  = fifo_full;
        s_acc   = m_busy && s_valid[m_owner] && !s_full;
        exp_oh  = m_busy ? (32'd1 << m_owner) : 32'd0;
        chk("grant", 32'(grant), exp_oh);
        chk("req_ack", 32'(req_ack), s_acc ? exp_oh : 32'd0);
        chk("fifo_wr", 32'(fifo_wr), 32'(s_acc));
        chk("fifo_data", 32'(fifo_data), m_busy ? 32'(req_data[m_owner*8 +: 8]) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("wr_while_full", 32'(fifo_wr & fifo_full), 32'd0);
        if (fifo_wr === 1'b1) wlog.push_back({grant, fifo_data});
        @(posedge clk);
        if (s_acc) void'(pq[m_owner].pop_front());
        model_step();
        #1;
    endtask

    function automatic bit all_done();
        bit d = !m_busy;
        for (int i = 0; i < N; i++) if (pq[i].size() > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!all_done() && n < max_cyc);
        chk("timeout", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic exp_push(input int p, input logic [7:0] d);
        logic [3:0] oh;
        oh = 4'd1 << p;
        exp_log.push_back({oh, d});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(wlog.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++)
            chk({tag, "_word"}, 32'(wlog[i]), 32'(exp_log[i]));
        wlog.delete();
        exp_log.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pq[i].delete();
        en_mask   = 4'hF;
        fifo_full = 1'b0;
        drive();
        clear_n = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        wlog.delete();
        exp_log.delete();
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_n   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        en_mask   = 4'hF;
        total_pushed = 0;
        model_reset();
        #1;
        do_reset();

        // Producer 0 streams 1,2,3; grant visible in the second cycle.
        pq[0] = {8'd1, 8'd2, 8'd3};
        cycle();
        chk("t1_grant_c2", 32'(grant), 32'h1);
        run_until_idle(20);
        exp_push(0, 8'd1); exp_push(0, 8'd2); exp_push(0, 8'd3);
        // rr_ptr is now 1, so producer 1 beats producer 0.
        pq[0] = {8'h0A};
        pq[1] = {8'h1A};
        run_until_idle(20);
        exp_push(1, 8'h1A); exp_push(0, 8'h0A);
        check_log("t1");

        // All producers continuously valid: bursts of 4 in order 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) pq[i].push_back(8'(i*16 + k));
        run_until_idle(200);
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < MB; j++) exp_push(b % N, 8'((b % N)*16 + (b / N)*MB + j));
        check_log("t2");

        // Full stall of 3 cycles after two beats of producer 1.
        do_reset();
        pq[1] = {8'h51, 8'h52, 8'h53, 8'h54};
        for (int n = 0; n < 20 && wlog.size() < 2; n++) cycle();
        fifo_full = 1'b1;
        repeat (3) cycle();
        chk("t3_stall_words", 32'(wlog.size()), 32'd2);
        fifo_full = 1'b0;
        run_until_idle(20);
        exp_push(1, 8'h51); exp_push(1, 8'h52); exp_push(1, 8'h53); exp_push(1, 8'h54);
        check_log("t3");

        // Asynchronous reset mid-burst.
        do_reset();
        pq[0] = {8'h61, 8'h62, 8'h63, 8'h64};
        cycle();
        cycle();
        clear_n = 1'b0;
        #1;
        chk("t4_async_grant", 32'(grant), 32'd0);
        chk("t4_async_wr", 32'(fifo_wr), 32'd0);
        chk("t4_async_ack", 32'(req_ack), 32'd0);
        #2;
        clear_n = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        model_reset();
        wlog.delete();
        pq[3] = {8'h71, 8'h72};
        cycle();
        chk("t4_p3_grant", 32'(grant), 32'h8);
        run_until_idle(20);
        // rr_ptr wrapped to 0: producer 0 wins over producer 3.
        pq[0] = {8'h81, 8'h82};
        pq[3] = {8'h73};
        run_until_idle(30);
        exp_push(3, 8'h71); exp_push(3, 8'h72);
        exp_push(0, 8'h81); exp_push(0, 8'h82); exp_push(3, 8'h73);
        check_log("t45");

        // Producer 2 stops after one beat; scan 3->0->1 picks producer 1.
        do_reset();
        pq[2] = {8'hA0};
        for (int n = 0; n < 10 && !m_busy; n++) cycle();
        pq[1] = {8'hB0, 8'hB1};
        run_until_idle(20);
        exp_push(2, 8'hA0); exp_push(1, 8'hB0); exp_push(1, 8'hB1);
        check_log("t6");

        // Random traffic with random valid gaps and fifo_full.
        do_reset();
        total_pushed = 0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 3 && $urandom_range(3) == 0) begin
                    pq[i].push_back(8'($urandom));
                    total_pushed++;
                end
                if ($urandom_range(7) == 0) en_mask[i] = ~en_mask[i];
            end
            fifo_full = ($urandom_range(4) == 0);
            cycle();
        end
        fifo_full = 1'b0;
        en_mask   = 4'hF;
        run_until_idle(300);
        chk("rand_total_words", 32'(wlog.size()), 32'(total_pushed));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one fifo instance among N_REQ producers.
- Grants the port in bursts of up to MAX_BURST words.
- Stalls cleanly on fifo full and never writes a full fifo.
- Sits between producer blocks and the fifo write side (wr, data_in, full).

Parameters:
- N_REQ, 4, number of producers sharing the fifo; minimum 2.
- DW, 8, data word width; must match the fifo data_in width.
- MAX_BURST, 4, maximum words accepted per grant before forced release; minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clear_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-producer word-available flags.
- req_data  input  N_REQ*DW  flattened producer data; producer i occupies bits [i*DW +: DW].
- req_ack  output  N_REQ  one-hot pulse: producer word accepted this cycle.
- fifo_wr  output  1  write strobe to the fifo wr input.
- fifo_data  output  DW  data to the fifo data_in input.
- fifo_full  input  1  fifo full flag.
- grant  output  N_REQ  one-hot current owner; all zero when IDLE.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE, grant=0, owner=0, rr_ptr=0, beat_cnt=0.
  - req_ack=0, fifo_wr=0, fifo_data=0, busy=0. Outputs drop immediately, without waiting for a clock edge.
- Registered state: state (IDLE/GRANT), owner index ($clog2(N_REQ) bits), rr_ptr (same width), beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If any req_valid is high, select the first valid index scanning rr_ptr, rr_ptr+1, … mod N_REQ (wraps).
  - Next cycle: owner<=index, state<=GRANT, beat_cnt<=0.
  - If no req_valid is high, stay in IDLE. No word is accepted in IDLE.
- GRANT, accept condition: accept = req_valid[owner] & ~fifo_full.
  - Combinational outputs: req_ack[owner]=accept, fifo_wr=accept, fifo_data=req_data[owner] slice.
  - fifo_data=0 when not in GRANT.
  - Zero latency from accept to fifo_wr.
  - On accept: beat_cnt increments.
- Release, taken at the clock edge after either event:
  - (a) accept with beat_cnt==MAX_BURST-1, i.e. the burst is complete; or
  - (b) req_valid[owner]==0 while in GRANT, i.e. the producer is done.
  - On release: state<=IDLE, rr_ptr<=(owner+1) mod N_REQ, beat_cnt<=0.
  - Exactly one IDLE turnaround cycle between grants.
- fifo_full=1 in GRANT:
  - No accept and no ack; beat_cnt is held.
  - Owner keeps the grant indefinitely, with no timeout.
  - Release rule (b) still applies.
- Producer protocol: req_data must be held stable while req_valid=1 and not acked. The arbiter never acks a non-owner.
- Invariants:
  - fifo_wr is never high while fifo_full is high.
  - At most one req_ack bit is high.
  - grant is one-hot or zero.
- Changes to non-owner req_valid during GRANT have no effect until the next IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE=1'b0, GRANT=1'b1), and an index-width helper constant derived from N_REQ.
- One natural sub-module: rr_pick. It is combinational; given req_valid and rr_ptr, it returns found and index using the wrap-around scan.
- The FSM, counter and datapath mux stay in fifo_wr_arbiter.

Test Plan:
- Reset, then producer 0 presents 1,2,3 with valid held for 3 words.
  - Grant in cycle 2; fifo_wr high 3 consecutive cycles with data 1,2,3; req_ack[0] pulses 3 times.
  - Release when valid drops; rr_ptr=1.
- All 4 producers valid continuously; producer i sends words i*16+k.
  - Grant order is 0,1,2,3,0; each burst is exactly 4 writes.
  - One idle cycle between bursts; no ack to a non-owner.
- fifo_full raised after 2 beats of producer 1's burst for 3 cycles.
  - fifo_wr and ack stay 0 during the stall; burst resumes and totals 4 words; no write while full.
- clear_n pulsed low mid-burst (asynchronously, between clock edges).
  - grant, fifo_wr and req_ack go 0 immediately.
  - After reset release, producer 3 alone valid → granted; rr_ptr scan starts at 0.
- Producer 3 only, rr_ptr=3, then producer 0 only after release.
  - Producer 3 is granted; after release rr_ptr wraps to 0; producer 0 is granted next.
- Producer 2 drops valid after 1 beat while producer 1 is valid.
  - Release; next grant goes to producer 1 via wrap scan from rr_ptr=3 (3→0→1); exactly one word is written from producer 2.
